// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier controller.
package vedic_pkg;

  localparam int N_DEFAULT = 8;
  localparam int H_DEFAULT = N_DEFAULT / 2;
  // Widest half-operand the partial-product helper supports (N up to 32).
  localparam int HALF_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_ADD_A = 3'd2,
    ST_ADD_B = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Half-width vertical-and-crosswise partial product; callers truncate to 2H bits.
  function automatic logic [2*HALF_MAX-1:0] half_mult(input logic [HALF_MAX-1:0] x,
                                                      input logic [HALF_MAX-1:0] y);
    return {{HALF_MAX{1'b0}}, x} * {{HALF_MAX{1'b0}}, y};
  endfunction

endpackage

// File: rtl/normal_add_8_bit.sv
// Ripple-carry adder of width N; the carry-out is dropped by design.
module normal_add_8_bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic w_carry;

  always_comb begin
    sum     = '0;
    w_carry = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/vedic_seq_mult_ctrl.sv
// N x N Vedic multiplier: four half-width partial products accumulated over
// two passes through one shared 2N-bit ripple adder.
module vedic_seq_mult_ctrl
  import vedic_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  localparam int H = N / 2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid/product hold steady until out_ready is seen.
  state_t           r_state;
  logic [N-1:0]     r_a, r_b;
  logic [N-1:0]     r_q0, r_q1, r_q2, r_q3;
  logic [2*N-1:0]   r_acc;
  logic             r_in_ready, r_out_valid, r_busy;

  logic [N-1:0]     w_pp0, w_pp1, w_pp2, w_pp3;
  logic [2*N-1:0]   w_add_a, w_add_b, w_sum;

  assign w_pp0 = N'(half_mult(HALF_MAX'(r_a[H-1:0]), HALF_MAX'(r_b[H-1:0])));
  assign w_pp1 = N'(half_mult(HALF_MAX'(r_a[N-1:H]), HALF_MAX'(r_b[H-1:0])));
  assign w_pp2 = N'(half_mult(HALF_MAX'(r_a[H-1:0]), HALF_MAX'(r_b[N-1:H])));
  assign w_pp3 = N'(half_mult(HALF_MAX'(r_a[N-1:H]), HALF_MAX'(r_b[N-1:H])));

  // Adder inputs held at zero outside the two accumulate states.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      ST_ADD_A: begin
        w_add_a = r_acc;
        w_add_b = {{H{1'b0}}, r_q1, {H{1'b0}}};
      end
      ST_ADD_B: begin
        w_add_a = r_acc;
        w_add_b = {{H{1'b0}}, r_q2, {H{1'b0}}};
      end
      default: begin
        w_add_a = '0;
        w_add_b = '0;
      end
    endcase
  end

  normal_add_8_bit #(.N(2*N)) u_adder (
    .a   (w_add_a),
    .b   (w_add_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_q0        <= '0;
      r_q1        <= '0;
      r_q2        <= '0;
      r_q3        <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_state    <= ST_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_MUL: begin
          r_q0    <= w_pp0;
          r_q1    <= w_pp1;
          r_q2    <= w_pp2;
          r_q3    <= w_pp3;
          r_acc   <= {w_pp3, w_pp0};
          r_state <= ST_ADD_A;
        end
        ST_ADD_A: begin
          r_acc   <= w_sum;
          r_state <= ST_ADD_B;
        end
        ST_ADD_B: begin
          r_acc       <= w_sum;
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_acc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Bench for vedic_seq_mult_ctrl: directed scenarios plus randomized operands
// checked against a plain a*b model through an expected-value queue.
module tb_vedic_seq_mult_ctrl;
  import vedic_pkg::*;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] product;
  logic           busy;
  logic [2:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cyc = 0;
  logic [2*N-1:0] exp_q[$];

  vedic_seq_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present operands for one edge (caller ensures in_ready) and record the model result
  task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    exp_q.push_back((2*N)'(xa) * (2*N)'(xb));
    tick();
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // waits for out_valid; lat is the cycle index of out_valid with the accept cycle as 0
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    ok = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    total++;
    if (dbg_state !== 3'(ST_IDLE)) begin
      bad++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [2*N-1:0] e;
    out_ready = 1'b1;
    send(8'h12, 8'h34);
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d required 4", lat);
    end
    total++;
    if (product !== 16'h03A8 || e !== 16'h03A8) begin
      bad++;
      $display("FAIL basic_product: got %h required %h", product, e);
    end
    tick();
    if (busy) bc++;
    total++;
    if (bc !== 4) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d required 4", bc);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_max();
    int lat, bc;
    logic [2*N-1:0] e;
    send(8'hFF, 8'hFF);
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (!out_valid || product !== 16'hFE01 || e !== 16'hFE01) begin
      bad++;
      $display("FAIL max_product: valid=%b got %h required %h", out_valid, product, e);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc, first_acc;
    bit ok;
    logic [2*N-1:0] e;
    send(8'h00, 8'hA5);
    first_acc = accept_cyc;
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (!out_valid || product !== e || e !== 16'h0000) begin
      bad++;
      $display("FAIL b2b_first: got %h required %h", product, e);
    end
    tick();
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_ready_timeout: in_ready=%b required 1", in_ready);
    end
    send(8'h01, 8'hA5);
    total++;
    if (accept_cyc - first_acc !== 5) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d required 5", accept_cyc - first_acc);
    end
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (!out_valid || product !== e || e !== 16'h00A5) begin
      bad++;
      $display("FAIL b2b_second: got %h required %h", product, e);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, bc, errs;
    logic [2*N-1:0] e;
    out_ready = 1'b0;
    send(8'h80, 8'h02);
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs != 0 || e !== 16'h0100) begin
      bad++;
      $display("FAIL backpressure_hold: %0d bad cycles, product=%h required %h", errs, product, e);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore();
    int lat, bc, extra;
    logic [2*N-1:0] e;
    send(8'h0F, 8'h0F);
    tick();
    a = 8'h11;
    b = 8'h11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (!out_valid || product !== e || e !== 16'h00E1) begin
      bad++;
      $display("FAIL ignore_product: got %h required %h", product, e);
    end
    tick();
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid || busy) extra++;
      tick();
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_no_second: %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, pulses;
    logic [2*N-1:0] e;
    send(8'h12, 8'h34);
    void'(exp_q.pop_back());
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset: out_valid=%b product=%h in_ready=%b busy=%b required 0 0000 1 0",
               out_valid, product, in_ready, busy);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL midreset_no_output: %0d valid cycles, required 0", pulses);
    end
    send(8'h03, 8'h05);
    wait_valid(lat, bc);
    e = exp_q.pop_front();
    total++;
    if (!out_valid || product !== e || e !== 16'h000F) begin
      bad++;
      $display("FAIL midreset_newop: got %h required %h", product, e);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bc, stall;
    bit ok;
    logic [2*N-1:0] e;
    for (int k = 0; k < 24; k++) begin
      wait_ready(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rand_ready_timeout: op %0d", k);
      end
      out_ready = 1'b0;
      send(N'($urandom), N'($urandom));
      wait_valid(lat, bc);
      e = exp_q.pop_front();
      total++;
      if (!out_valid || product !== e || lat !== 4) begin
        bad++;
        $display("FAIL rand_op%0d: valid=%b lat=%0d got %h required %h latency 4",
                 k, out_valid, lat, product, e);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
